hazard_flush_sequencer: RTL and testbench

//  Pipeline hazard and redirect controller for the 5-stage MIPS pipeline.

---
 rtl/hazard_flush_sequencer_pkg.sv | 27 ++
 rtl/hazard_flush_sequencer_sat_counter.sv | 24 ++
 rtl/hazard_flush_sequencer.sv | 137 +++++++++++++
 tb/tb_hazard_flush_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hazard_flush_sequencer_pkg.sv
// Shared pipeline definitions for the hazard/redirect controller.
//   PIPE_REG_W   : register-specifier width used across the pipeline
//   hfs_state_e  : controller state encoding
//   hfs_strobe_t : bundle of stage-register enables and flushes
package hazard_flush_sequencer_pkg;

  localparam int unsigned PIPE_REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_HOLD  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hfs_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
  } hfs_strobe_t;

  localparam hfs_strobe_t STROBE_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1,
                                              if_flush: 1'b0, id_flush: 1'b0,
                                              ex_flush: 1'b0};

endpackage

// File: rtl/hazard_flush_sequencer_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear
//   inc   : count enable for this cycle
//   count : current value; holds at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment unless already at the ceiling, so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_flush_sequencer.sv
// Hazard and redirect controller for the 5-stage pipeline.
// Drives PC / IF-ID write enables and IF, ID, EX flush strobes for
// load-use stalls, branch/jump redirects and data-memory waits.
//   clk, reset        : clock, synchronous active-high reset
//   id_rs, id_rt      : source fields of the IF/ID instruction
//   id_uses_rt        : IF/ID instruction reads rt
//   ex_mem_read,ex_rt : ID/EX load and its destination
//   pc_src            : branch resolved taken in EX
//   jump              : jump decoded in ID
//   mem_busy          : MEM-stage access not yet complete
//   pc_write, if_id_write, if_flush, id_flush, ex_flush : strobes (combinational)
//   stall_cnt, redir_cnt : saturating performance counters
module hazard_flush_sequencer
  import hazard_flush_sequencer_pkg::*;
#(
  parameter int unsigned REG_W = PIPE_REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             pc_src,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  hfs_state_e  state_q;
  hfs_state_e  state_d;
  logic        pend_br_q;
  logic        pend_br_d;
  logic        load_use;
  logic        lu_armed;
  logic        branch_hit;
  logic        stall_inc;
  logic        redir_inc;
  hfs_strobe_t strobe;

  // Load in EX writing a register the ID instruction reads; r0 never hazards.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // A branch taken while memory was busy is remembered until it can be applied.
  assign branch_hit = pc_src || pend_br_q;

  // LU_HOLD ignores load_use so each load produces exactly one bubble.
  always_comb begin
    lu_armed = 1'b1;
    case (state_q)
      ST_LU_HOLD: lu_armed = 1'b0;
      default:    lu_armed = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pend_br_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_br_q <= pend_br_d;
    end
  end

  // Next-state logic; every state not frozen by memory is evaluated as RUN.
  always_comb begin
    state_d   = ST_RUN;
    pend_br_d = pend_br_q;
    if (mem_busy) begin
      state_d   = ST_MEM_WAIT;
      pend_br_d = pend_br_q || pc_src;
    end else if (branch_hit) begin
      pend_br_d = 1'b0;
    end else if (!jump && load_use && lu_armed) begin
      state_d = ST_LU_HOLD;
    end
  end

  // Strobe and counter-enable logic.
  always_comb begin
    strobe    = STROBE_DEFAULT;
    stall_inc = 1'b0;
    redir_inc = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        strobe.pc_write    = 1'b0;
        strobe.if_id_write = 1'b0;
      end else if (branch_hit) begin
        // Any jump this cycle is on the wrong path and is dropped.
        strobe.if_flush = 1'b1;
        strobe.id_flush = 1'b1;
        strobe.ex_flush = 1'b1;
        redir_inc       = 1'b1;
      end else if (jump) begin
        strobe.if_flush = 1'b1;
        redir_inc       = 1'b1;
      end else if (load_use && lu_armed) begin
        strobe.pc_write    = 1'b0;
        strobe.if_id_write = 1'b0;
        strobe.id_flush    = 1'b1;
      end
      stall_inc = !strobe.pc_write;
    end
  end

  assign pc_write    = strobe.pc_write;
  assign if_id_write = strobe.if_id_write;
  assign if_flush    = strobe.if_flush;
  assign id_flush    = strobe.id_flush;
  assign ex_flush    = strobe.ex_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redir_inc),
    .count (redir_cnt)
  );

endmodule

// File: tb/tb_hazard_flush_sequencer.sv
// Scoreboard bench: directed vectors push expected strobes/counters,
// a negedge monitor pops and compares.
module tb_hazard_flush_sequencer;

  localparam int unsigned TB_REG_W = 5;
  localparam int unsigned TB_CNT_W = 4;

  // {pc_write, if_id_write, if_flush, id_flush, ex_flush}
  localparam logic [4:0] S_DEF = 5'b11000;
  localparam logic [4:0] S_LU  = 5'b00010;
  localparam logic [4:0] S_FRZ = 5'b00000;
  localparam logic [4:0] S_BR  = 5'b11111;
  localparam logic [4:0] S_JMP = 5'b11100;

  logic                clk = 1'b0;
  logic                reset;
  logic [TB_REG_W-1:0] id_rs, id_rt, ex_rt;
  logic                id_uses_rt, ex_mem_read, pc_src, jump, mem_busy;
  logic                pc_write, if_id_write, if_flush, id_flush, ex_flush;
  logic [TB_CNT_W-1:0] stall_cnt, redir_cnt;

  typedef struct {
    string      nm;
    logic [4:0] strobes;
    int         stall;
    int         redir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [4:0] mon_act;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_flush_sequencer #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .pc_src      (pc_src),
    .jump        (jump),
    .mem_busy    (mem_busy),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_flush    (if_flush),
    .id_flush    (id_flush),
    .ex_flush    (ex_flush),
    .stall_cnt   (stall_cnt),
    .redir_cnt   (redir_cnt)
  );

  // Monitor: the DUT presents strobes every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {pc_write, if_id_write, if_flush, id_flush, ex_flush};
      vectors++;
      if (mon_act !== mon_e.strobes) begin
        miscompares++;
        $display("FAIL %s strobes actual=%b required=%b", mon_e.nm, mon_act, mon_e.strobes);
      end
      if (stall_cnt !== TB_CNT_W'(mon_e.stall)) begin
        miscompares++;
        $display("FAIL %s stall_cnt actual=%0d required=%0d", mon_e.nm, stall_cnt, mon_e.stall);
      end
      if (redir_cnt !== TB_CNT_W'(mon_e.redir)) begin
        miscompares++;
        $display("FAIL %s redir_cnt actual=%0d required=%0d", mon_e.nm, redir_cnt, mon_e.redir);
      end
    end
  end

  task automatic vec(input string nm, input logic rst,
                     input logic [TB_REG_W-1:0] rs, input logic [TB_REG_W-1:0] rt,
                     input logic urt, input logic mr, input logic [TB_REG_W-1:0] ert,
                     input logic ps, input logic jp, input logic bz,
                     input logic [4:0] es, input int s, input int r);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = ert; pc_src = ps; jump = jp; mem_busy = bz;
    e.nm = nm; e.strobes = es; e.stall = s; e.redir = r;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [4:0] es, input int s, input int r);
    vec(nm, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, es, s, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt = '0; pc_src = 1'b0; jump = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset overrides active busy/branch inputs.
    vec("reset", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, S_DEF, 0, 0);
    // Load-use held two cycles: one bubble.
    vec("lu_stall", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, S_LU, 0, 0);
    vec("lu_hold",  1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, S_DEF, 1, 0);
    idle("lu_after", S_DEF, 1, 0);
    // Taken branch.
    vec("branch", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, S_BR, 1, 0);
    idle("branch_after", S_DEF, 1, 1);
    // Branch during a memory wait.
    vec("mw_1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_FRZ, 1, 1);
    vec("mw_2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, S_FRZ, 2, 1);
    vec("mw_3", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_FRZ, 3, 1);
    idle("mw_release", S_BR, 4, 1);
    idle("mw_after", S_DEF, 4, 2);
    // Branch + jump + load_use together.
    vec("br_jmp_lu", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, S_BR, 4, 2);
    idle("br_jmp_lu_after", S_DEF, 4, 3);
    // Register 0 never hazards; lone jump.
    vec("r0_no_stall", 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 4, 3);
    vec("jump", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, S_JMP, 4, 3);
    idle("jump_after", S_DEF, 4, 4);
    // rt-path hazard depends on id_uses_rt.
    vec("rt_stall", 1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, S_LU, 4, 4);
    idle("rt_hold", S_DEF, 5, 4);
    vec("rt_unused", 1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, S_DEF, 5, 4);
    // Jump handled in LU_HOLD, load_use ignored there.
    vec("lu2_stall", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, S_LU, 5, 4);
    vec("lu2_jump",  1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, S_JMP, 6, 4);
    idle("lu2_after", S_DEF, 6, 5);
    // Reset inside MEM_WAIT with a pending branch.
    vec("rw_busy", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_FRZ, 6, 5);
    vec("rw_pend", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, S_FRZ, 7, 5);
    vec("rw_reset", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 8, 5);
    idle("rw_release", S_DEF, 0, 0);
    idle("rw_after", S_DEF, 0, 0);
    // Stall counter saturation.
    for (int i = 0; i < 18; i++) begin
      vec("sat_stall", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_FRZ,
          (i > 15) ? 15 : i, 0);
    end
    idle("sat_stall_hold", S_BR == S_DEF ? S_FRZ : S_DEF, 15, 0);
    // Redirect counter saturation.
    for (int i = 0; i < 18; i++) begin
      vec("sat_redir", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, S_JMP,
          15, (i > 15) ? 15 : i);
    end
    idle("sat_redir_hold", S_DEF, 15, 15);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
